pattern_serial_loader: RTL and testbench
========================================

Name: pattern_serial_loader

Overview:
- Serial programming master for the pattern buffer's configuration shift interface: it drives sclk, ssel, saddr and sin, and captures sout.
- Accepts a load command carrying a buffer address and a stream of field bytes. It shifts one complete frame of buffer_size*buffer_width bits into the selected pattern buffer.
- Bits returned on sout are reassembled into bytes as readback of the previous buffer contents.
- Sits between the host/test controller and the patternbuffer serial port.

Parameters:
- buffer_size, 12, fields per pattern buffer (bytes per frame).
- buffer_width, 8, bits per field; shift/readback register width.
- clk_div, 2, sclk half-period in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- cmd_valid  in  1  load command request.
- cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid&&cmd_ready.
- cmd_addr  in  3  target buffer address, latched at accept.
- byte_in  in  buffer_width  next field byte, field 0 first.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  holding register empty and frame still needs bytes.
- abort  in  1  terminate frame immediately.
- sclk  out  1  serial clock, idles low.
- ssel  out  1  frame select, high for the whole frame.
- saddr  out  3  buffer address, stable while ssel high.
- sin  out  1  serial data, MSB first.
- sout  in  1  serial return data from buffer chain.
- rd_byte  out  buffer_width  reassembled readback byte.
- rd_valid  out  1  one-cycle pulse, rd_byte valid.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse on normal frame completion.

Behaviour:
- All outputs are registered.
- Reset values: sclk=0, ssel=0, saddr=0, sin=0, cmd_ready=1, byte_ready=0, rd_byte=0, rd_valid=0, busy=0, done=0. Reset also clears all counters and empties the holding register.
- Datapath: one holding register (byte_ready=!full while bytes remain to be requested) feeding one shift register. A byte counter (0..buffer_size-1), a bit counter (0..buffer_width-1) and a divider counter (0..clk_div-1) sequence the frame.
- FSM states: IDLE, WAIT_BYTE, LOW, HIGH, HOLD.
- IDLE -> WAIT_BYTE on accept. Next cycle: ssel=1, saddr=cmd_addr, busy=1, cmd_ready=0, byte_ready=1.
- WAIT_BYTE: sclk=0. When the holding register is full, move it to the shift register, drive sin=MSB, go to LOW.
- LOW: sclk=0 for clk_div cycles, then go to HIGH with sclk=1.
- On entry to HIGH (the rising-edge cycle), sample sout into the readback shift register LSB; readback bytes are MSB-first.
- HIGH: sclk=1 for clk_div cycles. At the end of HIGH:
  - Bit not last of byte: shift, sin=next bit, go to LOW.
  - Last bit, bytes remain, holding register full: reload, go to LOW.
  - Last bit, bytes remain, holding register empty: go to WAIT_BYTE. sclk stays low (stall, no partial edge); sin holds its last value.
  - Last bit of last byte: go to HOLD.
- rd_valid pulses one cycle after the rising edge carrying the last bit of each byte; exactly buffer_size pulses per completed frame.
- HOLD: sclk=0, ssel=1 for clk_div cycles. Then ssel=0, done=1 for one cycle, busy=0, cmd_ready=1, return to IDLE.
- Bytes offered beyond buffer_size are not accepted: byte_ready=0 once all bytes are fetched.
- abort, in any non-IDLE state: next cycle ssel=0, sclk=0, busy=0, cmd_ready=1. Holding register is emptied, done is not pulsed, partial readback is discarded.
- abort in IDLE: ignored.
- Reset mid-frame: same outputs as abort, plus reset values on all registers.
- Per frame: exactly buffer_size*buffer_width rising sclk edges; saddr never changes while ssel=1.
- No-stall frame length from accept to done: 1 + 2*clk_div*buffer_size*buffer_width + clk_div + 1 cycles.

Test Plan:
- Nominal load, clk_div=2, addr=5, bytes 0x01..0x0C always valid: 96 sclk rising edges 4 clks apart, saddr=5 throughout, sin matches MSB-first bitstream, done one cycle after ssel falls. Frame length = 1 + 384 + 2 + 1 = 388 clks from accept.
- Readback: model chain preloaded with 0xA5,0x5A,…, run a full load -> 12 rd_valid pulses with rd_byte equal to the preloaded values in field order. A second load returns the first frame's bytes.
- Byte stall: withhold byte_valid for 10 cycles before byte 3 -> sclk low and ssel high during the stall, no extra edges, total edges still 96, data intact.
- abort after 40 edges -> next cycle ssel=0, sclk=0, busy=0, no done. A following command completes normally with 96 edges.
- rst_n low mid-frame for 1 cycle -> all outputs return to reset values; cmd_ready=1 afterwards.
- clk_div=1 with byte_valid held high and extra bytes offered -> sclk toggles every clk, only 12 bytes accepted, byte_ready low after the 12th fetch.

Source files
------------

// File: rtl/pattern_serial_loader.sv
// Serial programming master for a pattern buffer: shifts one frame of field bytes out MSB-first
// on sclk/sin while reassembling the previous buffer contents returned on sout.
module pattern_serial_loader #(
  parameter int buffer_size  = 12,
  parameter int buffer_width = 8,
  parameter int clk_div      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_addr,
  input  logic [buffer_width-1:0] byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  input  logic                    abort,
  output logic                    sclk,
  output logic                    ssel,
  output logic [2:0]              saddr,
  output logic                    sin,
  input  logic                    sout,
  output logic [buffer_width-1:0] rd_byte,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done
);
  localparam int W  = buffer_width;
  localparam int BW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
  localparam int FW = $clog2(buffer_size + 1);
  localparam int TW = (buffer_width > 1) ? $clog2(buffer_width) : 1;
  localparam int DW = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(buffer_size - 1);
  localparam logic [TW-1:0] LAST_BIT  = TW'(buffer_width - 1);
  localparam logic [DW-1:0] LAST_DIV  = DW'(clk_div - 1);
  localparam logic [FW-1:0] N_BYTES   = FW'(buffer_size);

  typedef enum logic [2:0] {IDLE, WAIT_BYTE, LOW, HIGH, HOLD} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  byte_q, byte_d;
  logic [TW-1:0]  bit_q, bit_d;
  logic [DW-1:0]  div_q, div_d;
  logic [FW-1:0]  fetch_q, fetch_d;
  logic           hold_full_q, hold_full_d;
  logic [W-1:0]   hold_q, hold_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   rb_q, rb_d;
  logic           sclk_q, sclk_d, ssel_q, ssel_d, sin_q, sin_d;
  logic [2:0]     saddr_q, saddr_d;
  logic           cmd_ready_q, cmd_ready_d, byte_ready_q, byte_ready_d;
  logic [W-1:0]   rd_byte_q, rd_byte_d;
  logic           rd_valid_q, rd_valid_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    bit_d        = bit_q;
    div_d        = div_q;
    fetch_d      = fetch_q;
    hold_full_d  = hold_full_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    rb_d         = rb_q;
    sclk_d       = sclk_q;
    ssel_d       = ssel_q;
    sin_d        = sin_q;
    saddr_d      = saddr_q;
    cmd_ready_d  = cmd_ready_q;
    rd_byte_d    = rd_byte_q;
    rd_valid_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (byte_valid && byte_ready_q) begin
      hold_d      = byte_in;
      hold_full_d = 1'b1;
      fetch_d     = fetch_q + FW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = WAIT_BYTE;
          ssel_d      = 1'b1;
          saddr_d     = cmd_addr;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
          byte_d      = '0;
          bit_d       = '0;
          div_d       = '0;
          fetch_d     = '0;
          hold_full_d = 1'b0;
        end
      end
      WAIT_BYTE: begin
        sclk_d = 1'b0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          sin_d       = hold_q[W-1];
          hold_full_d = 1'b0;
          bit_d       = '0;
          div_d       = '0;
          state_d     = LOW;
        end
      end
      LOW: begin
        if (div_q == LAST_DIV) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
          // Returned bit is sampled on the rising-edge cycle, before the chain shifts.
          rb_d    = {rb_q[W-2:0], sout};
          if (bit_q == LAST_BIT) begin
            rd_byte_d  = {rb_q[W-2:0], sout};
            rd_valid_d = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HIGH: begin
        if (div_q == LAST_DIV) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != LAST_BIT) begin
            bit_d   = bit_q + TW'(1);
            shift_d = {shift_q[W-2:0], 1'b0};
            sin_d   = shift_q[W-2];
            state_d = LOW;
          end else if (byte_q != LAST_BYTE) begin
            byte_d = byte_q + BW'(1);
            bit_d  = '0;
            if (hold_full_q) begin
              shift_d     = hold_q;
              sin_d       = hold_q[W-1];
              hold_full_d = 1'b0;
              state_d     = LOW;
            end else begin
              state_d = WAIT_BYTE;
            end
          end else begin
            state_d = HOLD;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HOLD: begin
        sclk_d = 1'b0;
        if (div_q == LAST_DIV) begin
          div_d       = '0;
          ssel_d      = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort drops the frame without a done pulse and discards any partial readback.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      ssel_d      = 1'b0;
      sclk_d      = 1'b0;
      sin_d       = 1'b0;
      busy_d      = 1'b0;
      cmd_ready_d = 1'b1;
      hold_full_d = 1'b0;
      rb_d        = '0;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;
    end

    byte_ready_d = (state_d != IDLE) && !hold_full_d && (fetch_d < N_BYTES);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      fetch_q      <= '0;
      hold_full_q  <= 1'b0;
      sclk_q       <= 1'b0;
      ssel_q       <= 1'b0;
      sin_q        <= 1'b0;
      saddr_q      <= '0;
      cmd_ready_q  <= 1'b1;
      byte_ready_q <= 1'b0;
      rd_byte_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      fetch_q      <= fetch_d;
      hold_full_q  <= hold_full_d;
      sclk_q       <= sclk_d;
      ssel_q       <= ssel_d;
      sin_q        <= sin_d;
      saddr_q      <= saddr_d;
      cmd_ready_q  <= cmd_ready_d;
      byte_ready_q <= byte_ready_d;
      rd_byte_q    <= rd_byte_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
    rb_q    <= rb_d;
  end

  assign cmd_ready  = cmd_ready_q;
  assign byte_ready = byte_ready_q;
  assign sclk       = sclk_q;
  assign ssel       = ssel_q;
  assign saddr      = saddr_q;
  assign sin        = sin_q;
  assign rd_byte    = rd_byte_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_pattern_serial_loader.sv
// Directed bench for pattern_serial_loader: one instance at clk_div=2 with a 96-bit buffer
// chain model on sout, a second at clk_div=1; outputs of the selected instance are observed.
module tb_pattern_serial_loader;
  localparam logic [95:0] PRE = {8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0F, 8'hF0,
                                 8'h96, 8'h69, 8'hE1, 8'h1E, 8'h81, 8'h7E};

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, byte_valid, abort, sel;
  logic [2:0] cmd_addr;
  logic [7:0] byte_in;
  logic       cv_a, cv_b, sout_a, sout_b;
  logic       cmd_ready_a, byte_ready_a, sclk_a, ssel_a, sin_a, rd_valid_a, busy_a, done_a;
  logic       cmd_ready_b, byte_ready_b, sclk_b, ssel_b, sin_b, rd_valid_b, busy_b, done_b;
  logic [2:0] saddr_a, saddr_b;
  logic [7:0] rd_byte_a, rd_byte_b;
  logic       o_cmd_ready, o_byte_ready, o_sclk, o_ssel, o_sin, o_rd_valid, o_busy, o_done;
  logic [2:0] o_saddr;
  logic [7:0] o_rd_byte;

  logic [95:0] chain;
  logic        bits [96];
  logic [7:0]  tx [12];
  logic [7:0]  exp_rb [12];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign cv_a   = cmd_valid && !sel;
  assign cv_b   = cmd_valid && sel;
  assign sout_a = chain[95];
  assign sout_b = 1'b0;

  assign o_cmd_ready  = sel ? cmd_ready_b  : cmd_ready_a;
  assign o_byte_ready = sel ? byte_ready_b : byte_ready_a;
  assign o_sclk       = sel ? sclk_b       : sclk_a;
  assign o_ssel       = sel ? ssel_b       : ssel_a;
  assign o_saddr      = sel ? saddr_b      : saddr_a;
  assign o_sin        = sel ? sin_b        : sin_a;
  assign o_rd_byte    = sel ? rd_byte_b    : rd_byte_a;
  assign o_rd_valid   = sel ? rd_valid_b   : rd_valid_a;
  assign o_busy       = sel ? busy_b       : busy_a;
  assign o_done       = sel ? done_b       : done_a;

  pattern_serial_loader #(.buffer_size(12), .buffer_width(8), .clk_div(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv_a), .cmd_ready(cmd_ready_a), .cmd_addr(cmd_addr),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_a), .abort(abort),
    .sclk(sclk_a), .ssel(ssel_a), .saddr(saddr_a), .sin(sin_a), .sout(sout_a),
    .rd_byte(rd_byte_a), .rd_valid(rd_valid_a), .busy(busy_a), .done(done_a));

  pattern_serial_loader #(.buffer_size(12), .buffer_width(8), .clk_div(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv_b), .cmd_ready(cmd_ready_b), .cmd_addr(cmd_addr),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_b), .abort(abort),
    .sclk(sclk_b), .ssel(ssel_b), .saddr(saddr_b), .sin(sin_b), .sout(sout_b),
    .rd_byte(rd_byte_b), .rd_valid(rd_valid_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, o_sclk, o_ssel, o_saddr, o_sin, o_cmd_ready, o_byte_ready,
            o_rd_byte, o_rd_valid, o_busy, o_done};
  endfunction

  // exp_len = accept-to-done cycles, 0 when the frame must not complete.
  task automatic run_frame(input bit use_b, input logic [2:0] addr, input int n_offer,
                           input int stall_at, input int abort_at, input int rst_at,
                           input int exp_len, input bit chk_rb);
    int fed, wcnt, cyc, abort_cyc, tog, br_late, ecnt, saddr_err, bad;
    bit prev_bv, prev_br, prev_sclk, got_done, abort_sent;
    logic [7:0] rd_q[$];
    sel = use_b;
    fed = 0; wcnt = 0; tog = 0; br_late = 0; ecnt = 0; saddr_err = 0; abort_cyc = -1;
    prev_bv = 0; prev_br = 0; prev_sclk = 0; got_done = 0; abort_sent = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 3'd0;
    chk("accept_flags", {o_busy, o_ssel, o_cmd_ready, o_byte_ready}, 4'b1101);
    cyc = 0;
    while (cyc < 4000) begin
      if (prev_bv && prev_br) fed++;
      if (o_sclk && !prev_sclk && ecnt < 96) begin
        bits[ecnt] = o_sin;
        ecnt++;
        if (!use_b) chain = {chain[94:0], o_sin};
      end
      if (o_sclk != prev_sclk) tog++;
      prev_sclk = o_sclk;
      if (o_ssel && o_saddr !== addr) saddr_err++;
      if (fed >= 12 && o_byte_ready) br_late++;
      if (o_rd_valid) rd_q.push_back(o_rd_byte);
      if (o_done) begin
        got_done = 1;
        break;
      end
      if (abort_sent && cyc == abort_cyc + 1)
        chk("abort_outputs", {o_ssel, o_sclk, o_busy, o_cmd_ready}, 4'b0001);
      if (abort_sent && cyc == abort_cyc + 20) break;
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        chk("midframe_reset", outs(), 32'h0000_1000);
        break;
      end
      abort = 1'b0;
      rst_n = 1'b1;
      if (rst_at >= 0 && cyc == rst_at) rst_n = 1'b0;
      if (abort_at >= 0 && !abort_sent && ecnt >= abort_at) begin
        abort = 1'b1; abort_sent = 1; abort_cyc = cyc;
      end
      byte_valid = (fed < n_offer);
      byte_in    = (fed < 12) ? tx[fed] : 8'hEE;
      if (fed == stall_at && o_byte_ready && wcnt < 40) begin
        byte_valid = 1'b0;
        wcnt++;
        if (wcnt == 38) chk("stall_lines", {o_sclk, o_ssel}, 2'b01);
      end
      prev_bv = byte_valid;
      prev_br = o_byte_ready;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0; abort = 1'b0; rst_n = 1'b1;

    chk("saddr_stable", saddr_err, 0);
    if (exp_len > 0) begin
      chk("done_seen", got_done, 1);
      chk("frame_len", cyc, exp_len);
      chk("ssel_at_done", o_ssel, 0);
      chk("sclk_edges", ecnt, 96);
      bad = 0;
      for (int i = 0; i < 96; i++)
        if (i >= ecnt || bits[i] !== tx[i/8][7-(i%8)]) bad++;
      chk("sin_stream_errs", bad, 0);
    end else begin
      chk("no_done", got_done, 0);
    end
    if (abort_at >= 0) chk("abort_edges", ecnt, abort_at);
    if (chk_rb) begin
      chk("rd_count", rd_q.size(), 12);
      bad = 0;
      for (int i = 0; i < 12; i++)
        if (i >= rd_q.size() || rd_q[i] !== exp_rb[i]) bad++;
      chk("rd_bytes_errs", bad, 0);
    end
    if (use_b) begin
      chk("sclk_toggles", tog, 192);
      chk("bytes_fetched", fed, 12);
      chk("byte_ready_late", br_late, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 3'd0; byte_valid = 1'b0;
    byte_in = 8'd0; abort = 1'b0; sel = 1'b0;
    chain = PRE;
    repeat (3) @(negedge clk);
    chk("reset_a", outs(), 32'h0000_1000);
    sel = 1'b1;
    #1;
    chk("reset_b", outs(), 32'h0000_1000);
    rst_n = 1'b1; sel = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      tx[i] = 8'(i + 1);
      exp_rb[i] = PRE[95-8*i -: 8];
    end
    run_frame(0, 3'd5, 12, -1, -1, -1, 388, 1);

    for (int i = 0; i < 12; i++) begin
      exp_rb[i] = tx[i];
      tx[i] = 8'(8'h35 * (i + 1));
    end
    run_frame(0, 3'd3, 12, -1, -1, -1, 388, 1);

    for (int i = 0; i < 12; i++) begin
      exp_rb[i] = tx[i];
      tx[i] = 8'(8'hC6 ^ (i * 8'h11));
    end
    run_frame(0, 3'd6, 12, 3, -1, -1, 398, 1);

    run_frame(0, 3'd2, 12, -1, 40, -1, 0, 0);
    run_frame(0, 3'd7, 12, -1, -1, -1, 388, 0);
    run_frame(0, 3'd1, 12, -1, -1, 100, 0, 0);
    run_frame(1, 3'd4, 14, -1, -1, -1, 195, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
